// File: rtl/rf_write_sched.sv
// Write-port scheduler for the 4x8-bit register file: round-robin arbitration with an
// optional grant lock, registering the winning request for capture on the next negedge.
module rf_write_sched #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      req_lock,
    input  logic [N-1:0]      req_en1,
    input  logic [N-1:0]      req_en2,
    input  logic [2*N-1:0]    req_reg1,
    input  logic [2*N-1:0]    req_reg2,
    input  logic [16*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic [1:0]        write_reg1,
    output logic [1:0]        write_reg2,
    output logic [15:0]       write_data,
    output logic              write_en1,
    output logic              write_en2,
    output logic [3:0]        pending_mask,
    output logic              conflict,
    output logic [1:0]        dbg_ptr,
    output logic              dbg_lock_active
);

    // Handshake: request i transfers on a posedge where req_valid[i] && req_ready[i];
    // a requester holds its fields stable until then but may drop req_valid freely.

    logic [1:0]  ptr_q;
    logic [1:0]  lock_owner_q;
    logic        lock_active_q;
    logic [1:0]  write_reg1_q, write_reg2_q;
    logic [15:0] write_data_q;
    logic        write_en1_q, write_en2_q, conflict_q;

    logic        owner_valid;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  ptr_d;
    logic [1:0]  sel_reg1, sel_reg2;
    logic [15:0] sel_data;
    logic        sel_en1, sel_en2, sel_lock, same_reg;
    int          scan_idx;

    always_comb begin
        owner_valid = 1'b0;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 0;
        for (int i = 0; i < N; i++) begin
            if (lock_owner_q == 2'(i) && req_valid[i]) owner_valid = 1'b1;
        end
        if (!hold) begin
            if (lock_active_q && owner_valid) begin
                grant_found = 1'b1;
                grant_idx   = lock_owner_q;
            end else begin
                // Scan ptr, ptr+1, ... mod N; the first valid index wins.
                for (int k = 0; k < N; k++) begin
                    scan_idx = int'(ptr_q) + k;
                    if (scan_idx >= N) scan_idx = scan_idx - N;
                    for (int i = 0; i < N; i++) begin
                        if (!grant_found && i == scan_idx && req_valid[i]) begin
                            grant_found = 1'b1;
                            grant_idx   = 2'(i);
                        end
                    end
                end
            end
        end

        req_ready = '0;
        sel_reg1  = 2'd0;
        sel_reg2  = 2'd0;
        sel_data  = 16'h0000;
        sel_en1   = 1'b0;
        sel_en2   = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == 2'(i)) begin
                req_ready[i] = grant_found;
                sel_reg1     = req_reg1[2*i +: 2];
                sel_reg2     = req_reg2[2*i +: 2];
                sel_data     = req_data[16*i +: 16];
                sel_en1      = req_en1[i];
                sel_en2      = req_en2[i];
                sel_lock     = req_lock[i];
            end
        end
        same_reg = sel_en1 && sel_en2 && (sel_reg1 == sel_reg2);
        ptr_d    = (int'(grant_idx) == N - 1) ? 2'd0 : grant_idx + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= 2'd0;
            lock_owner_q  <= 2'd0;
            lock_active_q <= 1'b0;
            write_reg1_q  <= 2'd0;
            write_reg2_q  <= 2'd0;
            write_data_q  <= 16'h0000;
            write_en1_q   <= 1'b0;
            write_en2_q   <= 1'b0;
            conflict_q    <= 1'b0;
        end else if (grant_found) begin
            write_reg1_q  <= sel_reg1;
            write_reg2_q  <= sel_reg2;
            write_data_q  <= sel_data;
            // On a same-register clash the LSB byte wins, so the MSB enable is dropped.
            write_en1_q   <= sel_en1 && !same_reg;
            write_en2_q   <= sel_en2;
            conflict_q    <= same_reg;
            ptr_q         <= ptr_d;
            lock_active_q <= sel_lock;
            lock_owner_q  <= grant_idx;
        end else begin
            write_en1_q   <= 1'b0;
            write_en2_q   <= 1'b0;
            conflict_q    <= 1'b0;
            if (lock_active_q && !owner_valid) lock_active_q <= 1'b0;
        end
    end

    assign write_reg1      = write_reg1_q;
    assign write_reg2      = write_reg2_q;
    assign write_data      = write_data_q;
    assign write_en1       = write_en1_q;
    assign write_en2       = write_en2_q;
    assign conflict        = conflict_q;
    assign dbg_ptr         = ptr_q;
    assign dbg_lock_active = lock_active_q;
    assign pending_mask    = ((4'b0001 << write_reg1_q) & {4{write_en1_q}})
                           | ((4'b0001 << write_reg2_q) & {4{write_en2_q}});

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched (N=3): round-robin order, field transfer, conflict
// handling, lock, hold and asynchronous reset, each scenario in its own task.
module tb_rf_write_sched;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic [N-1:0]      req_valid, req_lock, req_en1, req_en2;
    logic [2*N-1:0]    req_reg1, req_reg2;
    logic [16*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [1:0]        write_reg1, write_reg2;
    logic [15:0]       write_data;
    logic              write_en1, write_en2;
    logic [3:0]        pending_mask;
    logic              conflict;
    logic [1:0]        dbg_ptr;
    logic              dbg_lock_active;

    int n_cmp = 0;
    int n_bad = 0;

    rf_write_sched #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_lock(req_lock), .req_en1(req_en1), .req_en2(req_en2),
        .req_reg1(req_reg1), .req_reg2(req_reg2), .req_data(req_data),
        .req_ready(req_ready), .write_reg1(write_reg1), .write_reg2(write_reg2),
        .write_data(write_data), .write_en1(write_en1), .write_en2(write_en2),
        .pending_mask(pending_mask), .conflict(conflict),
        .dbg_ptr(dbg_ptr), .dbg_lock_active(dbg_lock_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic v, input logic lk, input logic e1,
                           input logic e2, input logic [1:0] r1, input logic [1:0] r2,
                           input logic [15:0] d);
        req_valid[i]         = v;
        req_lock[i]          = lk;
        req_en1[i]           = e1;
        req_en2[i]           = e2;
        req_reg1[2*i +: 2]   = r1;
        req_reg2[2*i +: 2]   = r2;
        req_data[16*i +: 16] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_lock = '0; req_en1 = '0; req_en2 = '0;
        req_reg1 = '0; req_reg2 = '0; req_data = '0;
    endtask

    // Requester i: reg1=i, reg2=3, data=0xC000+i, both enables, no lock.
    task automatic set_all_std();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 1'b1, 2'(i), 2'd3, 16'(16'hC000 + i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold  = 1'b0;
        clear_reqs();
        #12;
        n_cmp++; if ({write_en1, write_en2, conflict} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b exp 000", {write_en1, write_en2, conflict}); end
        n_cmp++; if ({write_reg1, write_reg2} !== 4'b0000) begin n_bad++; $display("FAIL reset_regs: got %b exp 0000", {write_reg1, write_reg2}); end
        n_cmp++; if (write_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h exp 0000", write_data); end
        n_cmp++; if (pending_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_pending: got %b exp 0000", pending_mask); end
        n_cmp++; if ({dbg_ptr, dbg_lock_active} !== 3'b000) begin n_bad++; $display("FAIL reset_ptr_lock: got %b exp 000", {dbg_ptr, dbg_lock_active}); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int g;
        for (int k = 0; k < 6; k++) begin
            g = k % 3;
            @(negedge clk);
            set_all_std();
            #1;
            n_cmp++; if (req_ready !== 3'(1 << g)) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, req_ready, 3'(1 << g)); end
            @(posedge clk); #1;
            n_cmp++; if (write_data !== 16'(16'hC000 + g)) begin n_bad++; $display("FAIL rr_data[%0d]: got %h exp %h", k, write_data, 16'(16'hC000 + g)); end
            n_cmp++; if (pending_mask !== (4'(1 << g) | 4'b1000)) begin n_bad++; $display("FAIL rr_pending[%0d]: got %b exp %b", k, pending_mask, 4'(1 << g) | 4'b1000); end
            n_cmp++; if (dbg_ptr !== 2'((g + 1) % 3)) begin n_bad++; $display("FAIL rr_ptr[%0d]: got %0d exp %0d", k, dbg_ptr, (g + 1) % 3); end
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 16'hA55A);
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL single_ready: got %b exp 010", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({write_reg1, write_reg2} !== {2'd2, 2'd3}) begin n_bad++; $display("FAIL single_regs: got %b exp 1011", {write_reg1, write_reg2}); end
        n_cmp++; if (write_data !== 16'hA55A) begin n_bad++; $display("FAIL single_data: got %h exp a55a", write_data); end
        n_cmp++; if ({write_en1, write_en2, conflict} !== 3'b110) begin n_bad++; $display("FAIL single_flags: got %b exp 110", {write_en1, write_en2, conflict}); end
        n_cmp++; if (pending_mask !== 4'b1100) begin n_bad++; $display("FAIL single_pending: got %b exp 1100", pending_mask); end
        n_cmp++; if (dbg_ptr !== 2'd2) begin n_bad++; $display("FAIL single_ptr: got %0d exp 2", dbg_ptr); end
        @(negedge clk);
        clear_reqs();
        @(posedge clk); #1;
        n_cmp++; if ({write_en1, write_en2} !== 2'b00) begin n_bad++; $display("FAIL idle_en: got %b exp 00", {write_en1, write_en2}); end
        n_cmp++; if (write_data !== 16'hA55A) begin n_bad++; $display("FAIL idle_data_hold: got %h exp a55a", write_data); end
        n_cmp++; if ({pending_mask, dbg_ptr} !== {4'b0000, 2'd2}) begin n_bad++; $display("FAIL idle_pending_ptr: got %b exp 000010", {pending_mask, dbg_ptr}); end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 16'h1234);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL conflict_ready: got %b exp 001", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({write_en1, write_en2, conflict} !== 3'b011) begin n_bad++; $display("FAIL conflict_flags: got %b exp 011", {write_en1, write_en2, conflict}); end
        n_cmp++; if (pending_mask !== 4'b0010) begin n_bad++; $display("FAIL conflict_pending: got %b exp 0010", pending_mask); end
        n_cmp++; if ({write_data, dbg_ptr} !== {16'h1234, 2'd1}) begin n_bad++; $display("FAIL conflict_data_ptr: got %h/%0d exp 1234/1", write_data, dbg_ptr); end
        @(negedge clk);
        clear_reqs();
        @(posedge clk); #1;
        n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL conflict_clear: got %b exp 0", conflict); end
    endtask

    task automatic test_lock();
        int   exp_g [6];
        logic lk_in [6];
        logic exp_lk;
        exp_g = '{1, 2, 2, 2, 2, 0};
        lk_in = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_all_std();
            req_lock[2] = lk_in[k];
            #1;
            n_cmp++; if (req_ready !== 3'(1 << exp_g[k])) begin n_bad++; $display("FAIL lock_ready[%0d]: got %b exp %b", k, req_ready, 3'(1 << exp_g[k])); end
            @(posedge clk); #1;
            exp_lk = (exp_g[k] == 2) && lk_in[k];
            n_cmp++; if (dbg_lock_active !== exp_lk) begin n_bad++; $display("FAIL lock_state[%0d]: got %b exp %b", k, dbg_lock_active, exp_lk); end
            n_cmp++; if (write_data !== 16'(16'hC000 + exp_g[k])) begin n_bad++; $display("FAIL lock_data[%0d]: got %h exp %h", k, write_data, 16'(16'hC000 + exp_g[k])); end
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_all_std();
            hold = 1'b1;
            #1;
            n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b exp 000", k, req_ready); end
            @(posedge clk); #1;
            n_cmp++; if ({write_en1, write_en2, dbg_ptr} !== {2'b00, 2'd1}) begin n_bad++; $display("FAIL hold_en_ptr[%0d]: got %b exp 0001", k, {write_en1, write_en2, dbg_ptr}); end
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL hold_resume: got %b exp 010", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({write_data, dbg_ptr} !== {16'hC001, 2'd2}) begin n_bad++; $display("FAIL hold_resume_write: got %h/%0d exp c001/2", write_data, dbg_ptr); end
    endtask

    task automatic test_hold_with_lock();
        @(negedge clk);
        req_lock[2] = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL hl_first_ready: got %b exp 100", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({dbg_lock_active, dbg_ptr} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL hl_locked: got %b exp 100", {dbg_lock_active, dbg_ptr}); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            hold = 1'b1;
            req_lock[2] = 1'b0;
            #1;
            n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL hl_hold_ready[%0d]: got %b exp 000", k, req_ready); end
            @(posedge clk); #1;
            n_cmp++; if ({dbg_lock_active, write_en2} !== 2'b10) begin n_bad++; $display("FAIL hl_lock_kept[%0d]: got %b exp 10", k, {dbg_lock_active, write_en2}); end
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL hl_owner_regrant: got %b exp 100", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({write_data, dbg_lock_active} !== {16'hC002, 1'b0}) begin n_bad++; $display("FAIL hl_release: got %h/%b exp c002/0", write_data, dbg_lock_active); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_all_std();
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rm_ready: got %b exp 001", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({write_en1, write_en2, dbg_ptr} !== {2'b11, 2'd1}) begin n_bad++; $display("FAIL rm_accept: got %b exp 1101", {write_en1, write_en2, dbg_ptr}); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({write_en1, write_en2, pending_mask} !== 6'b000000) begin n_bad++; $display("FAIL rm_cancel: got %b exp 000000", {write_en1, write_en2, pending_mask}); end
        n_cmp++; if ({dbg_ptr, dbg_lock_active} !== 3'b000) begin n_bad++; $display("FAIL rm_ptr: got %b exp 000", {dbg_ptr, dbg_lock_active}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({write_data, dbg_ptr} !== {16'hC000, 2'd1}) begin n_bad++; $display("FAIL rm_after: got %h/%0d exp c000/1", write_data, dbg_ptr); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_conflict();
        test_lock();
        test_hold();
        test_hold_with_lock();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 4×8-bit register file. It arbitrates among N requesters (ALU, load path, immediate/move path) that each want to drive the file's two write ports (a 16-bit `write_data` split MSB→reg1, LSB→reg2) in the same cycle. Arbitration is round-robin with an optional lock for back-to-back atomic writes. The granted request is registered on the rising edge, so it is stable when the file captures on the following falling edge.

## Interface
- `N`, 3: number of requesters (2..4); requester i occupies slice i of each packed vector.
- `clk` in 1: system clock; internal state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hold` in 1: freeze arbitration; no grants while high.
- `req_valid` in N: request i present.
- `req_lock` in N: keep the grant with requester i for its next request.
- `req_en1` in N: request i writes MSB byte to `req_reg1`.
- `req_en2` in N: request i writes LSB byte to `req_reg2`.
- `req_reg1` in 2N: destination for MSB, bits [2i+1:2i].
- `req_reg2` in 2N: destination for LSB, bits [2i+1:2i].
- `req_data` in 16N: data, bits [16i+15:16i].
- `req_ready` out N: one-hot grant; request i is accepted when `req_valid[i] && req_ready[i]`.
- `write_reg1`, `write_reg2` out 2 each: registered register-file write addresses.
- `write_data` out 16: registered register-file write data.
- `write_en1`, `write_en2` out 1 each: registered register-file write enables.
- `pending_mask` out 4: bit r set when a registered enable targets register r this cycle.
- `conflict` out 1: registered flag; the accepted request had both enables with `reg1 == reg2`.

## Operation
- Grant is combinational from `req_valid`, `hold`, `ptr`, `lock_owner`:
  - `hold` = 1: `req_ready` = 0.
  - Lock active and its owner is valid: grant the owner.
  - Otherwise: the first valid index scanning `ptr`, `ptr+1`, … mod N.
  - No valid requests: `req_ready` = 0.
- On the posedge with acceptance of requester g:
  - Output registers load g's `reg1`, `reg2`, `data`, `en1`, `en2`.
  - `ptr` ← (g+1) mod N.
  - If `req_lock[g]`: `lock_owner` ← g, lock active. Otherwise the lock clears.
- On a posedge with no acceptance:
  - `write_en1` and `write_en2` ← 0.
  - Address and data registers hold their values.
  - `ptr` unchanged.
  - The lock clears if its owner is not valid. It is kept if only `hold` blocked the grant.
- Same-register conflict (`en1 && en2 && reg1 == reg2`):
  - `write_en1` is registered as 0, so the LSB byte wins deterministically.
  - `conflict` = 1 for that cycle. Otherwise `conflict` = 0.
- `pending_mask` = onehot(`write_reg1`) & {4{`write_en1`}} | onehot(`write_reg2`) & {4{`write_en2`}}. Readers use it to detect a write landing this cycle.
- An accepted request with both enables 0 still consumes the grant and advances `ptr`. It produces no write.
- `ptr` range is 0..N-1 and wraps from N-1 to 0.

## Timing
- Reset (async assert, sync release):
  - `write_en1`, `write_en2`, `conflict` = 0.
  - `write_reg1`, `write_reg2` = 0; `write_data` = 0x0000.
  - `ptr` = 0; lock inactive.
- `req_ready` and `pending_mask` are combinational with no registers of their own. They reset implicitly through their inputs.
- Latency:
  - Accepted at posedge k; outputs valid from k until posedge k+1.
  - The file captures at the negedge between them, so a write lands half a cycle after acceptance.
- Throughput: one request per cycle with no bubbles.
- Requesters must hold their fields stable while `req_valid` is high and not accepted. They may drop `req_valid` at any time before acceptance.
- Reset mid-operation: a registered write is cancelled immediately because the enables are forced to 0 asynchronously.
- Simultaneous `hold` and lock: `hold` wins. The lock is retained.

## Test plan
- Reset, then requesters 0, 1, 2 all valid continuously (N=3) -> grants 0,1,2,0,… one per cycle; `ptr` wraps 2→0.
- Requester 1 only: reg1=2, reg2=3, data=0xA55A, both enables -> next cycle `write_reg1`=2, `write_reg2`=3, `write_data`=0xA55A, both enables 1, `pending_mask`=4'b1100.
- Requester 0: en1=en2=1, reg1=reg2=1, data=0x1234 -> `write_en1`=0, `write_en2`=1, `conflict`=1, `pending_mask`=4'b0010.
- Requester 2 with `req_lock`=1 while 0 and 1 are valid -> requester 2 is granted on consecutive cycles. After it drops lock, the grant moves to 0.
- `hold`=1 for 3 cycles with all requesters valid -> `req_ready`=0 and enables 0 throughout. After release, the grant resumes at the unchanged `ptr`.
- Accept a write, then assert `rst_n`=0 mid-cycle -> `write_en1` and `write_en2` drop to 0 before the negedge, and `ptr` = 0.
